ram8_bank: RTL and testbench



---
 rtl/ram8_bank_if.sv | 23 ++
 rtl/ram8_bank.sv | 79 +++++++
 tb/tb_ram8_bank.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram8_bank_if.sv
// Host-side bus of the eight-entry register bank: write port, read select,
// clear request and clear-engine status.
interface ram8_bank_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic [2:0]       address;
    logic             load;
    logic             clear;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             clear_done;

    modport master (
        output in, address, load, clear,
        input  out, busy, clear_done
    );

    modport slave (
        input  in, address, load, clear,
        output out, busy, clear_done
    );
endinterface

// File: rtl/ram8_bank.sv
// Eight-entry register bank with one-hot load decode, combinational read mux
// and a one-entry-per-cycle clear sweep reported through busy/clear_done.
module ram8_bank #(
    parameter int unsigned WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ram8_bank_if.slave  bus
);
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] ld;
    logic             busy_q;
    logic             done_q;

    // One-hot load decode; a same-edge clear or a running sweep drops the write.
    always_comb begin
        ld = '0;
        if (bus.load && !busy_q && !bus.clear) begin
            ld[bus.address] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        state  <= SWEEP;
                        busy_q <= 1'b1;
                        ptr    <= '0;
                    end else begin
                        for (int i = 0; i < int'(DEPTH); i++) begin
                            if (ld[i]) begin
                                mem[i] <= bus.in;
                            end
                        end
                    end
                end
                SWEEP: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + AW'(1);
                    // Last entry: hand back to IDLE and flag completion for one cycle.
                    if (ptr == AW'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out        = mem[bus.address];
    assign bus.busy       = busy_q;
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank: vector table for writes, a queue-based
// readback scoreboard, and hand sequences for the clear sweep corner cases.
`timescale 1ns/10ps
module tb_ram8_bank;
    logic clk;
    logic rst_n;

    ram8_bank_if #(.WIDTH(16)) bus ();

    ram8_bank #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_out;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } sb_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [8];
    sb_t sb_q [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        bus.address = a;
        bus.in      = d;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
        model[a]    = d;
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 8; i++) begin
            bus.address = 3'(i);
            #0.1;
            chk(name, bus.out, model[i]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
        end
    endtask

    initial begin
        vec_t vecs [8];
        sb_t  e;
        int   busy_cycles;
        int   done_cycles;

        rst_n       = 1'b0;
        bus.in      = '0;
        bus.address = '0;
        bus.load    = 1'b0;
        bus.clear   = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        // Reset state, before any clock edge
        #2;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.clear_done), 16'd0);
        check_all("rst_out");
        @(negedge clk);
        rst_n = 1'b1;

        // Write/readback from a vector table; readback through the scoreboard queue
        for (int i = 0; i < 8; i++) begin
            vecs[i].addr    = 3'(i);
            vecs[i].data    = 16'(16'h1111 * (i + 1));
            vecs[i].exp_out = vecs[i].data;
        end
        for (int i = 0; i < 8; i++) begin
            write(vecs[i].addr, vecs[i].data);
            chk("write_out", bus.out, vecs[i].exp_out);
            e.addr = vecs[i].addr;
            e.data = vecs[i].exp_out;
            sb_q.push_back(e);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.address = e.addr;
            #0.1;
            chk("readback", bus.out, e.data);
        end

        // Decode isolation
        write(3'd5, 16'hBEEF);
        check_all("isolation");

        // Clear sweep observed on address 7
        for (int i = 0; i < 8; i++) write(3'(i), 16'hFFFF);
        bus.address = 3'd7;
        bus.clear   = 1'b1;
        tick();
        bus.clear   = 1'b0;
        chk("sweep_busy_rise", 16'(bus.busy), 16'd1);
        chk("sweep_a7_k", bus.out, 16'hFFFF);
        busy_cycles = 1;
        done_cycles = 0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 3) begin
                bus.address = 3'd0;
                #0.1;
                chk("sweep_a0_cleared", bus.out, 16'h0000);
                bus.address = 3'd5;
                #0.1;
                chk("sweep_a5_kept", bus.out, 16'hFFFF);
                bus.address = 3'd7;
                #0.1;
            end
            if (j < 8) chk("sweep_a7_old", bus.out, 16'hFFFF);
            else       chk("sweep_a7_zero", bus.out, 16'h0000);
            chk("sweep_done", 16'(bus.clear_done), (j == 8) ? 16'd1 : 16'd0);
            if (bus.busy) busy_cycles++;
            if (bus.clear_done) done_cycles++;
        end
        chk("sweep_busy_cycles", 16'(busy_cycles), 16'd8);
        chk("sweep_done_pulses", 16'(done_cycles), 16'd1);
        for (int i = 0; i < 8; i++) model[i] = '0;
        check_all("sweep_all_zero");

        // Load during sweep is ignored
        for (int i = 0; i < 8; i++) write(3'(i), 16'hA5A5);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        tick();
        write(3'd0, 16'h1234);
        model[0] = 16'h0000;
        wait_idle("load_in_sweep");
        for (int i = 0; i < 8; i++) model[i] = '0;
        bus.address = 3'd0;
        #0.1;
        chk("load_in_sweep_a0", bus.out, 16'h0000);

        // Load and clear on the same idle edge
        write(3'd3, 16'h7777);
        bus.address = 3'd3;
        bus.in      = 16'h5555;
        bus.load    = 1'b1;
        bus.clear   = 1'b1;
        tick();
        bus.load    = 1'b0;
        bus.clear   = 1'b0;
        chk("collide_busy", 16'(bus.busy), 16'd1);
        chk("collide_dropped", bus.out, 16'h7777);
        wait_idle("collide");
        model[3] = 16'h0000;
        chk("collide_a3", bus.out, 16'h0000);

        // Clear held high: back-to-back sweeps, one idle cycle between
        bus.clear = 1'b1;
        tick();
        for (int j = 1; j <= 7; j++) tick();
        chk("held_busy_k7", 16'(bus.busy), 16'd1);
        tick();
        chk("held_busy_k8", 16'(bus.busy), 16'd0);
        chk("held_done_k8", 16'(bus.clear_done), 16'd1);
        tick();
        chk("held_restart", 16'(bus.busy), 16'd1);
        chk("held_done_k9", 16'(bus.clear_done), 16'd0);
        bus.clear = 1'b0;
        wait_idle("held");
        tick();

        // Reset in the middle of a sweep
        write(3'd2, 16'h2222);
        write(3'd6, 16'h6666);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #0.1;
        chk("mid_rst_busy", 16'(bus.busy), 16'd0);
        chk("mid_rst_done", 16'(bus.clear_done), 16'd0);
        for (int i = 0; i < 8; i++) model[i] = '0;
        check_all("mid_rst_out");
        @(negedge clk);
        rst_n = 1'b1;
        write(3'd6, 16'h00AA);
        chk("post_rst_a6", bus.out, 16'h00AA);
        chk("post_rst_busy", 16'(bus.busy), 16'd0);
        check_all("post_rst_all");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
